// File: rtl/i2c_cam_target.sv
// I2C target answering at DEV_ADDR with a byte-wide register file behind it.
// A write's first data byte loads the pointer; later bytes land in the
// register file and are echoed on cfg_*. Reads stream the file from the
// pointer. The host port preloads bytes at any time.
module i2c_cam_target #(
  parameter logic [6:0] DEV_ADDR = 7'h58,
  parameter int         AW       = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_data,
  output logic          cfg_wr,
  output logic [AW-1:0] cfg_addr,
  output logic [7:0]    cfg_data,
  output logic          busy,
  output logic [AW-1:0] ptr
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    scl_q, sda_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          first_q, first_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          cfg_wr_q, cfg_wr_d;
  logic [AW-1:0] cfg_addr_q, cfg_addr_d;
  logic [7:0]    cfg_data_q, cfg_data_d;
  logic [7:0]    mem_q [2**AW];
  logic          bus_we;

  // Synchronised levels ([1]) and one cycle of history ([2]) for edge detect.
  logic scl_rise, scl_fall, start_c, stop_c, sda_s;
  logic [7:0] shift_in;
  assign sda_s    = sda_q[1];
  assign scl_rise =  scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] &  scl_q[2];
  assign start_c  = scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_c   = scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];
  assign shift_in = {shreg_q[6:0], sda_s};

  // Two-flop synchronisers plus history; reset to the idle (released) level
  // so leaving reset never fakes a bus condition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  // Protocol state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      first_q    <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      cfg_wr_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      first_q    <= first_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      cfg_wr_q   <= cfg_wr_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
    end
  end

  // Register file: the bus write is issued last so it wins an address clash.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else begin
      if (host_we) mem_q[host_addr] <= host_data;
      if (bus_we)  mem_q[ptr_q]     <= shift_in;
    end
  end

  // Next state: START/STOP override everything; bits sample on SCL rise,
  // SDA drive changes on SCL fall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    first_d    = first_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    cfg_wr_d   = 1'b0;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    bus_we     = 1'b0;
    if (start_c) begin
      state_d  = ADDR;
      cnt_d    = '0;
      busy_d   = 1'b1;
      sda_oe_d = 1'b0;
    end else if (stop_c) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shreg_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shreg_q[7:1] == DEV_ADDR) begin
              sda_oe_d = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              state_d  = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (shreg_q[0]) begin
              shreg_d  = mem_q[ptr_q];
              sda_oe_d = ~mem_q[ptr_q][7];
              state_d  = RD_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              first_d  = 1'b1;
              state_d  = WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shreg_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (first_q) begin
                ptr_d   = shift_in[AW-1:0];
                first_d = 1'b0;
              end else begin
                bus_we     = 1'b1;
                cfg_wr_d   = 1'b1;
                cfg_addr_d = ptr_q;
                cfg_data_d = shift_in;
                ptr_d      = ptr_q + AW'(1);
              end
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
        end
        RD_ACK: begin
          // Pointer advances past the byte just sent whether ACKed or not.
          if (scl_rise) begin
            ptr_d = ptr_q + AW'(1);
            if (sda_s) state_d = IGNORE;
          end else if (scl_fall) begin
            shreg_d  = mem_q[ptr_q];
            sda_oe_d = ~mem_q[ptr_q][7];
            cnt_d    = '0;
            state_d  = RD_BYTE;
          end
        end
        IGNORE:  sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign ptr      = ptr_q;
  assign cfg_wr   = cfg_wr_q;
  assign cfg_addr = cfg_addr_q;
  assign cfg_data = cfg_data_q;

endmodule

// File: tb/tb_i2c_cam_target.sv
// Bench for i2c_cam_target: a bit-banged I2C master on an open-drain SDA,
// a reference register-file model, and scoreboard monitors for cfg_wr
// pulses and read-back bytes.
module tb_i2c_cam_target;
  localparam int AW = 6;
  localparam int Q  = 10;
  localparam int H  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          scl_m = 1'b1;
  logic          sda_low = 1'b0;
  logic          sda_line;
  logic          sda_oe;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_data = '0;
  logic          cfg_wr;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_data;
  logic          busy;
  logic [AW-1:0] ptr;

  assign sda_line = ~(sda_low | sda_oe);

  always #5 clk = ~clk;

  i2c_cam_target #(.DEV_ADDR(7'h58), .AW(AW)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .host_we(host_we), .host_addr(host_addr),
    .host_data(host_data), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .busy(busy), .ptr(ptr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: register file contents and pointer.
  logic [7:0]    mem_m [64];
  logic [AW-1:0] ptr_m = '0;
  logic [AW+7:0] exp_cfg [$];
  logic [7:0]    exp_rd [$];
  logic [7:0]    wd [8];
  logic [7:0]    rd_obs;
  event          rd_ev;
  bit            watch = 1'b0;
  bit            drive_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wbit(input bit b);
    wt(H); sda_low = ~b; wt(H); scl_m = 1'b1; wt(Q); scl_m = 1'b0;
  endtask

  task automatic rbit(output bit v);
    wt(H); sda_low = 1'b0; wt(H); scl_m = 1'b1; wt(Q); v = sda_line; scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wt(H); sda_low = 1'b0; wt(H); scl_m = 1'b1; wt(Q); sda_low = 1'b1; wt(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wt(H); sda_low = 1'b1; wt(H); scl_m = 1'b1; wt(Q); sda_low = 1'b0; wt(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output bit ack);
    bit v;
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(v);
    ack = ~v;
  endtask

  task automatic rbyte(input bit nack, output logic [7:0] b);
    bit v;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      rbit(v);
      b = {b[6:0], v};
    end
    wbit(nack);
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_data = d;
    @(negedge clk);
    host_we = 1'b0;
    mem_m[a] = d;
  endtask

  // Address byte a, then n data bytes from wd[]; the model decides what the
  // target should do with them.
  task automatic wr_txn(input logic [7:0] a, input int n, input bit do_stop);
    bit ack;
    bit hit;
    hit = (a[7:1] == 7'h58);
    i2c_start();
    chk("busy_after_start", busy, 1);
    wbyte(a, ack);
    chk("addr_ack", ack, hit);
    for (int i = 0; i < n; i++) begin
      if (hit && !a[0]) begin
        if (i == 0) ptr_m = wd[0][AW-1:0];
        else begin
          exp_cfg.push_back({ptr_m, wd[i]});
          mem_m[ptr_m] = wd[i];
          ptr_m = ptr_m + 1'b1;
        end
      end
      wbyte(wd[i], ack);
      chk("data_ack", ack, hit && !a[0]);
    end
    if (do_stop) begin
      i2c_stop();
      chk("busy_after_stop", busy, 0);
      chk("ptr_after_write", ptr, ptr_m);
    end
  endtask

  task automatic rd_txn(input int n);
    bit ack;
    logic [7:0] b;
    i2c_start();
    wbyte(8'hB1, ack);
    chk("read_addr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(mem_m[ptr_m]);
      ptr_m = ptr_m + 1'b1;
      rbyte(i == n - 1, b);
      rd_obs = b;
      ->rd_ev;
    end
    i2c_stop();
    chk("busy_after_read", busy, 0);
    chk("ptr_after_read", ptr, ptr_m);
  endtask

  // cfg_wr scoreboard.
  always @(negedge clk) begin
    logic [AW+7:0] e;
    if (cfg_wr) begin
      if (exp_cfg.size() == 0) chk("cfg_unexpected", 1, 0);
      else begin
        e = exp_cfg.pop_front();
        chk("cfg_addr", cfg_addr, e[AW+7:8]);
        chk("cfg_data", cfg_data, e[7:0]);
      end
    end
  end

  // Read-data scoreboard.
  initial begin
    forever begin
      @(rd_ev);
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", rd_obs, exp_rd.pop_front());
    end
  end

  // Flags any SDA drive while a non-addressed transaction is on the bus.
  always @(negedge clk) if (watch && sda_oe) drive_seen = 1'b1;

  initial begin
    #800000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ack;
    logic [6:0] a7;
    int kind, n;
    for (int k = 0; k < 64; k++) mem_m[k] = '0;
    wt(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_cfg_wr", cfg_wr, 0);
    chk("rst_cfg_addr", cfg_addr, 0);
    chk("rst_cfg_data", cfg_data, 0);
    reset = 1'b1;
    wt(5);

    // Configuration write 0x30 <- 0x01.
    wd[0] = 8'h30; wd[1] = 8'h01;
    wr_txn(8'hB0, 2, 1'b1);
    chk("ptr_cfg_write", ptr, 6'h31);

    // Wrong device address: nothing driven, nothing written.
    drive_seen = 1'b0; watch = 1'b1;
    wd[0] = 8'h30; wd[1] = 8'hA5;
    wr_txn(8'hB2, 2, 1'b1);
    watch = 1'b0;
    chk("wrong_addr_no_drive", drive_seen, 0);
    chk("wrong_addr_ptr", ptr, 6'h31);
    wd[0] = 8'h30;
    wr_txn(8'hB0, 1, 1'b0);
    rd_txn(1);

    // Preload, pointer 0x36, repeated start, 16-byte read across the wrap.
    for (int k = 0; k < 64; k++) host_wr(AW'(k), 8'(k + 8'h10));
    wd[0] = 8'h36;
    wr_txn(8'hB0, 1, 1'b0);
    rd_txn(16);
    chk("ptr_wrap", ptr, 6'd6);

    // Pointer 0x33 then two data bytes.
    wd[0] = 8'h33; wd[1] = 8'h33; wd[2] = 8'hAA;
    wr_txn(8'hB0, 3, 1'b1);
    chk("ptr_two_bytes", ptr, 6'h35);
    wd[0] = 8'h33;
    wr_txn(8'hB0, 1, 1'b0);
    rd_txn(2);

    // STOP after 4 bits of a data byte.
    i2c_start();
    wbyte(8'hB0, ack);
    wbyte(8'h20, ack);
    ptr_m = 6'h20;
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    i2c_stop();
    chk("partial_busy", busy, 0);
    chk("partial_ptr", ptr, 6'h20);
    wd[0] = 8'h20;
    wr_txn(8'hB0, 1, 1'b0);
    rd_txn(1);

    // Randomised mix of writes, pointer+reads, plain reads and foreign traffic.
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1)
        host_wr(AW'($urandom), 8'($urandom));
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          n = int'($urandom_range(1, 4));
          for (int i = 0; i <= n; i++) wd[i] = 8'($urandom);
          wr_txn(8'hB0, n + 1, 1'b1);
        end
        1: begin
          wd[0] = 8'($urandom);
          wr_txn(8'hB0, 1, 1'b0);
          rd_txn(int'($urandom_range(1, 5)));
        end
        2: begin
          a7 = 7'($urandom);
          if (a7 == 7'h58) a7 = 7'h21;
          wd[0] = 8'($urandom); wd[1] = 8'($urandom);
          wr_txn({a7, 1'($urandom)}, 2, 1'b1);
        end
        default: rd_txn(int'($urandom_range(1, 4)));
      endcase
    end

    // Reset while the target holds SDA low mid-read.
    host_wr(6'h05, 8'h12);
    wd[0] = 8'h05;
    wr_txn(8'hB0, 1, 1'b1);
    i2c_start();
    wbyte(8'hB1, ack);
    chk("pre_reset_ack", ack, 1);
    wt(4);
    chk("pre_reset_sda_driven", sda_oe, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_sda_oe", sda_oe, 0);
    chk("async_reset_ptr", ptr, 0);
    for (int k = 0; k < 64; k++) mem_m[k] = '0;
    ptr_m = '0;
    wt(3);
    reset = 1'b1;
    sda_low = 1'b0;
    wt(5);
    i2c_stop();
    rd_txn(1);

    wt(5);
    chk("cfg_queue_drained", exp_cfg.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_cam_target.md
Name: i2c_cam_target

Overview:
- I2C target (responder) emulating the IR camera's bus face at 7-bit address 0x58.
- Answers configuration writes (e.g. 0x30←0x01, 0x30←0x08, 0x33←0x33), the 0x36 pointer write and the following multi-byte blob reads, from an internal register file.
- Sits opposite the camera-controller/i2c_master pair: as a loopback target in FPGA self-test builds, and as the synthesizable bus model in benches.
- The user side preloads blob bytes through a host write port.

Parameters:
- DEV_ADDR, 7'h58, target address matched against the address byte.
- AW, 6, register-file address width; depth 2**AW bytes; the pointer wraps modulo 2**AW.

Ports:
- clk  in  1  system clock; must be ≥8× the SCL frequency.
- reset  in  1  asynchronous, active-low reset.
- scl_in  in  1  raw SCL pad input.
- sda_in  in  1  raw SDA pad input.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- host_we  in  1  host write strobe.
- host_addr  in  AW  host write address.
- host_data  in  8  host write data.
- cfg_wr  out  1  one-cycle pulse per byte written by the bus master.
- cfg_addr  out  AW  address of the last bus-written byte.
- cfg_data  out  8  value of the last bus-written byte.
- busy  out  1  high from START until STOP, or until return to IDLE.
- ptr  out  AW  current register pointer.

Behaviour:
- **Reset (async, active-low):** sda_oe=0, cfg_wr=0, cfg_addr=0, cfg_data=0, busy=0, ptr=0, all register-file bytes=0, state=IDLE.
- **Input sync:** scl/sda each pass through 2 FFs, plus a 1-FF history for edge detection. Condition detection latency is 3 clk from the pad.
- **START:** synced SDA falls while SCL high. Accepted in any state (covers repeated start). Clears the bit counter, sets busy=1, state→ADDR, sda_oe=0.
- **STOP:** SDA rises while SCL high. Accepted in any state → IDLE, busy=0, sda_oe=0. A STOP mid-byte discards the partial byte; there is no register write.
- **Sampling:** data is sampled on SCL rising. sda_oe changes only on SCL falling. A new bit is presented on the falling edge ending the previous bit.
- **States:** IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- **ADDR:** shift 8 bits, MSB first.
  - Bits[7:1]==DEV_ADDR: on the 8th falling edge set sda_oe=1 → ADDR_ACK.
  - Otherwise → IGNORE, and SDA is never driven.
- **ADDR_ACK:** on the next falling edge, release SDA.
  - RW=0 → WR_BYTE with first_byte=1.
  - RW=1 → RD_BYTE: load shreg=mem[ptr] and drive bit7 on that same falling edge (sda_oe = ~bit).
- **WR_BYTE:** after 8 bits, on the 8th falling edge assert the ACK (sda_oe=1) → WR_ACK.
  - Byte commit happens at the 8th rising edge:
    - if first_byte: ptr = byte[AW-1:0] and first_byte=0;
    - else: mem[ptr]=byte, cfg_wr pulses for 1 clk with cfg_addr=ptr and cfg_data=byte, then ptr=ptr+1 (wraps).
  - All bytes are ACKed.
- **WR_ACK:** release on the next falling edge → WR_BYTE.
- **RD_BYTE:** present shreg MSB first, sda_oe = ~bit. After the 8th bit, release on the falling edge → RD_ACK.
- **RD_ACK:** sample SDA on the rising edge.
  - 0 (ACK): ptr=ptr+1 (wrap); on the falling edge load mem[ptr] and drive bit7 → RD_BYTE.
  - 1 (NACK): → IGNORE, and ptr is still incremented past the last byte sent.
- **IGNORE:** sda_oe=0 and all bits ignored; exits only on START or STOP.
- **ptr persistence:** ptr persists across transactions, so "write 0x36, STOP/Sr, read N" returns mem[0x36..].
- **Host writes:** host_we writes mem[host_addr] in any state, 1-cycle latency.
  - A host write and a bus write to the same address in the same clk: the bus write wins.
  - A byte already loaded into shreg is unaffected by later host writes.
- **cfg_wr:** never asserted for host writes, for the pointer byte, or for partial bytes.

Test Plan:
- Write [0xB0,0x30,0x01], STOP → ACK on all 3 bytes; mem[0x30]=0x01; one cfg_wr pulse with cfg_addr=0x30 and cfg_data=0x01; ptr=0x31; busy low after STOP.
- Write [0xB2,0x30,0x01] (address 0x59) → SDA never driven; no cfg_wr; mem unchanged; busy returns to 0 on STOP.
- Host preloads mem[k]=k+0x10 for all k; write [0xB0,0x36]; repeated START; read address 0xB1; read 16 bytes with ACK on the first 15 and NACK on the last:
  - expected bytes: 0x46..0x4F, then 0x10..0x15 (wrap at 63→0);
  - final ptr=6.
- Write [0xB0,0x33,0x33,0xAA] → mem[0x33]=0x33, mem[0x34]=0xAA; two cfg_wr pulses; ptr=0x35.
- STOP after 4 data bits of a write byte → no cfg_wr; mem unchanged; state IDLE.
- Assert reset mid-read while SDA driven low → sda_oe=0 immediately (async); ptr=0; after reset release, the next read at 0x58 (with no pointer write) returns 0x00 from the cleared mem[0].
